// File: rtl/fc_neuron_seq_if.sv
// Bus bundle for fc_neuron_seq: weight-write port, activation stream and result handshake.
// FC_NEURON_SEQ_BIAS_EN widens the address (bias slot at IN) and the accumulator by one bit.
interface fc_neuron_seq_if #(
    parameter int WIDTH   = 8,
    parameter int W_WIDTH = 8,
    parameter int IN      = 84,
    parameter int LANES   = 4
);
`ifdef FC_NEURON_SEQ_BIAS_EN
    localparam int ADDR_W = $clog2(IN + 1);
    localparam int ACC_W  = WIDTH + W_WIDTH + $clog2(IN) + 2;
`else
    localparam int ADDR_W = (IN > 1) ? $clog2(IN) : 1;
    localparam int ACC_W  = WIDTH + W_WIDTH + $clog2(IN) + 1;
`endif

    logic                      w_we;
    logic [ADDR_W-1:0]         w_addr;
    logic signed [W_WIDTH-1:0] w_data;
    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH*LANES-1:0]    in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [ACC_W-2:0]          z;
    logic                      busy;

    modport master (
        output w_we, w_addr, w_data, in_valid, in_data, out_ready,
        input  in_ready, out_valid, z, busy
    );

    modport slave (
        input  w_we, w_addr, w_data, in_valid, in_data, out_ready,
        output in_ready, out_valid, z, busy
    );
endinterface

// File: rtl/fc_neuron_seq.sv
// Time-multiplexed fully-connected neuron: z = ReLU(sum x[i]*w[i]), LANES products per beat.
// Optional bias register (address IN) when FC_NEURON_SEQ_BIAS_EN is defined.
module fc_neuron_seq #(
    parameter int WIDTH   = 8,
    parameter int W_WIDTH = 8,
    parameter int IN      = 84,
    parameter int LANES   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    fc_neuron_seq_if.slave   io_bus
);
    localparam int BEATS = (IN + LANES - 1) / LANES;
    localparam int PAD   = BEATS * LANES;
    localparam int IDX_W = (PAD > 1) ? $clog2(PAD) : 1;
    localparam int CNT_W = $clog2(BEATS + 1);
`ifdef FC_NEURON_SEQ_BIAS_EN
    localparam int ADDR_W = $clog2(IN + 1);
    localparam int ACC_W  = WIDTH + W_WIDTH + $clog2(IN) + 2;
    localparam int BIAS_W = W_WIDTH + WIDTH;
`else
    localparam int ADDR_W = (IN > 1) ? $clog2(IN) : 1;
    localparam int ACC_W  = WIDTH + W_WIDTH + $clog2(IN) + 1;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_DONE} state_t;

    state_t                     r_state;
    state_t                     w_state_nx;
    logic                       r_live;
    logic [CNT_W-1:0]           r_cnt;
    logic signed [ACC_W-1:0]    r_acc;
    logic [ACC_W-2:0]           r_z;
    logic signed [W_WIDTH-1:0]  r_weights [IN];
    logic signed [W_WIDTH-1:0]  w_wpad [PAD];
    logic [IDX_W-1:0]           w_idx;
    logic signed [ACC_W-1:0]    w_base;
    logic signed [ACC_W-1:0]    w_partial;
    logic signed [ACC_W-1:0]    w_sum;
    logic                       w_in_ready;
    logic                       w_accept;
    logic                       w_last;

`ifdef FC_NEURON_SEQ_BIAS_EN
    logic signed [BIAS_W-1:0]   r_bias;
    assign w_base = ACC_W'(r_bias);
`else
    assign w_base = '0;
`endif

    // Pad the weight table to a whole number of beats; tail lanes see weight 0 so their data drops out.
    for (genvar i = 0; i < PAD; i++) begin : g_pad
        if (i < IN) begin : g_w
            assign w_wpad[i] = r_weights[i];
        end else begin : g_z
            assign w_wpad[i] = '0;
        end
    end

    assign w_in_ready = r_live && (r_state != ST_DONE);
    assign w_accept   = io_bus.in_valid && w_in_ready;
    assign w_last     = (r_cnt == CNT_W'(BEATS - 1));

    always_comb begin
        w_partial = '0;
        w_idx     = '0;
        for (int k = 0; k < LANES; k++) begin
            w_idx     = IDX_W'(r_cnt) * IDX_W'(LANES) + IDX_W'(k);
            w_partial = w_partial
                      + ACC_W'($signed({1'b0, io_bus.in_data[k*WIDTH +: WIDTH]}))
                      * ACC_W'(w_wpad[w_idx]);
        end
    end

    assign w_sum = ((r_state == ST_IDLE) ? w_base : r_acc) + w_partial;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE, ST_ACC: begin
                if (w_accept) begin
                    w_state_nx = w_last ? ST_DONE : ST_ACC;
                end
            end
            ST_DONE: begin
                if (io_bus.out_ready) begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // Weight writes share the IDLE edge with a first beat; that beat still reads the old table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live <= 1'b0;
            r_cnt  <= '0;
            r_acc  <= '0;
            r_z    <= '0;
            for (int i = 0; i < IN; i++) begin
                r_weights[i] <= '0;
            end
`ifdef FC_NEURON_SEQ_BIAS_EN
            r_bias <= '0;
`endif
        end else begin
            r_live <= 1'b1;
            if (w_accept) begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_z <= w_sum[ACC_W-1] ? '0 : w_sum[ACC_W-2:0];
                end
            end else if ((r_state == ST_DONE) && io_bus.out_ready) begin
                r_acc <= '0;
                r_cnt <= '0;
            end
            if ((r_state == ST_IDLE) && io_bus.w_we) begin
                for (int i = 0; i < IN; i++) begin
                    if (io_bus.w_addr == ADDR_W'(i)) begin
                        r_weights[i] <= io_bus.w_data;
                    end
                end
`ifdef FC_NEURON_SEQ_BIAS_EN
                if (io_bus.w_addr == ADDR_W'(IN)) begin
                    r_bias <= BIAS_W'(io_bus.w_data);
                end
`endif
            end
        end
    end

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.out_valid = (r_state == ST_DONE);
    assign io_bus.z         = r_z;
    assign io_bus.busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fc_neuron_seq.sv
// Self-checking bench for fc_neuron_seq: dot-product model with per-cycle compare plus literal checks.
// Also exercises a small IN=6 instance; bias cases run when FC_NEURON_SEQ_BIAS_EN is defined.
module tb_fc_neuron_seq;
    localparam int WIDTH   = 8;
    localparam int W_WIDTH = 8;
    localparam int IN      = 84;
    localparam int LANES   = 4;
    localparam int BEATS   = 21;
    localparam int IN2     = 6;
`ifdef FC_NEURON_SEQ_BIAS_EN
    localparam int ADDR_W  = $clog2(IN + 1);
    localparam int ADDR2_W = $clog2(IN2 + 1);
`else
    localparam int ADDR_W  = $clog2(IN);
    localparam int ADDR2_W = $clog2(IN2);
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fc_neuron_seq_if #(.WIDTH(WIDTH), .W_WIDTH(W_WIDTH), .IN(IN),  .LANES(LANES)) bus  ();
    fc_neuron_seq_if #(.WIDTH(WIDTH), .W_WIDTH(W_WIDTH), .IN(IN2), .LANES(LANES)) bus2 ();

    fc_neuron_seq #(.WIDTH(WIDTH), .W_WIDTH(W_WIDTH), .IN(IN), .LANES(LANES)) dut (
        .clk(clk), .rst_n(rst_n), .io_bus(bus)
    );
    fc_neuron_seq #(.WIDTH(WIDTH), .W_WIDTH(W_WIDTH), .IN(IN2), .LANES(LANES)) dut2 (
        .clk(clk), .rst_n(rst_n), .io_bus(bus2)
    );

    int nChecks = 0;
    int nFails  = 0;
    int tbX [IN];

    int     mW [IN];
    int     mSnapW [IN];
    int     mX [IN];
    int     mBias = 0;
    int     mSnapBias = 0;
    int     mBeats = 0;
    bit     mPend = 1'b0;
    bit     mLive = 1'b0;
    bit     mIdle;
    bit     mAcc;
    longint mRaw = 0;
    longint mZ = 0;
    int     dutHs = 0;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        nChecks++;
        if (actual != expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: collect the accepted activations, then take the dot product with the weights seen at beat 0.
    initial begin
        foreach (mW[i]) begin mW[i] = 0; mX[i] = 0; mSnapW[i] = 0; end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                foreach (mW[i]) mW[i] = 0;
                mBias = 0; mBeats = 0; mPend = 1'b0; mLive = 1'b0;
            end else begin
                mIdle = !mPend && (mBeats == 0);
                mAcc  = bus.in_valid && mLive && !mPend;
                if (mAcc) begin
                    if (mBeats == 0) begin
                        mSnapW = mW;
                        mSnapBias = mBias;
                    end
                    for (int k = 0; k < LANES; k++) begin
                        if (mBeats * LANES + k < IN)
                            mX[mBeats * LANES + k] = int'(bus.in_data[k*WIDTH +: WIDTH]);
                    end
                    mBeats++;
                    if (mBeats == BEATS) begin
                        mRaw = mSnapBias;
                        for (int i = 0; i < IN; i++) mRaw += longint'(mX[i]) * mSnapW[i];
                        mZ = (mRaw < 0) ? 0 : mRaw;
                        mPend = 1'b1;
                        mBeats = 0;
                    end
                end else if (mPend && bus.out_ready) begin
                    mPend = 1'b0;
                end
                if (mIdle && bus.w_we) begin
                    if (bus.w_addr < IN) mW[bus.w_addr] = int'(bus.w_data);
`ifdef FC_NEURON_SEQ_BIAS_EN
                    else if (bus.w_addr == ADDR_W'(IN)) mBias = int'(bus.w_data);
`endif
                end
                mLive = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            checkOutput("in_ready", bus.in_ready, mLive && !mPend);
            checkOutput("out_valid", bus.out_valid, mPend);
            checkOutput("busy", bus.busy, mPend || (mBeats != 0));
            if (mPend) checkOutput("z", bus.z, mZ);
            if (bus.out_valid && bus.out_ready) dutHs++;
        end
    end

    task automatic writeWeight(input int addr, input int data);
        bus.w_we = 1'b1; bus.w_addr = ADDR_W'(addr); bus.w_data = W_WIDTH'(data);
        @(posedge clk); #1;
        bus.w_we = 1'b0;
    endtask

    task automatic loadWeights(input int mode);
        for (int i = 0; i < IN; i++) begin
            if (mode == 0)      writeWeight(i, 1);
            else if (mode == 1) writeWeight(i, -1);
            else                writeWeight(i, (i % 2 == 0) ? 3 : -2);
        end
    endtask

    task automatic applyStimulus(input int nBeats, input int gapMax, input int wrBeat,
                                 input int wrAddr, input int wrData, output int cycles);
        bit got;
        int tries;
        cycles = 0;
        for (int b = 0; b < nBeats; b++) begin
            if (gapMax > 0) begin
                repeat ($urandom_range(0, gapMax)) begin
                    bus.in_valid = 1'b0; @(posedge clk); #1; cycles++;
                end
            end
            bus.in_valid = 1'b1;
            for (int k = 0; k < LANES; k++) begin
                if (b * LANES + k < IN) bus.in_data[k*WIDTH +: WIDTH] = WIDTH'(tbX[b * LANES + k]);
                else                    bus.in_data[k*WIDTH +: WIDTH] = 8'hA5;
            end
            if (b == wrBeat) begin
                bus.w_we = 1'b1; bus.w_addr = ADDR_W'(wrAddr); bus.w_data = W_WIDTH'(wrData);
            end
            got = 1'b0; tries = 0;
            while (!got && tries < 50) begin
                @(negedge clk); got = bus.in_ready;
                @(posedge clk); #1; cycles++; tries++;
            end
            if (!got) checkOutput("beat_accept_timeout", 0, 1);
            bus.w_we = 1'b0;
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int cyc;
        int hsBefore;
        bus.w_we = 0; bus.w_addr = '0; bus.w_data = '0;
        bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 1'b1;
        bus2.w_we = 0; bus2.w_addr = '0; bus2.w_data = '0;
        bus2.in_valid = 0; bus2.in_data = '0; bus2.out_ready = 1'b1;

        #12;
        checkOutput("rst_in_ready", bus.in_ready, 0);
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_z", bus.z, 0);
        @(posedge clk); #1; rst_n = 1'b1; #1;
        checkOutput("in_ready_before_first_edge", bus.in_ready, 0);
        @(posedge clk); #1;
        checkOutput("in_ready_after_first_edge", bus.in_ready, 1);

        $display("[TB] all-ones vector");
        loadWeights(0);
        foreach (tbX[i]) tbX[i] = 1;
        applyStimulus(BEATS, 0, -1, 0, 0, cyc);
        checkOutput("t1_beat_cycles", cyc, BEATS);
        checkOutput("t1_valid_latency", bus.out_valid, 1);
        checkOutput("t1_z", bus.z, 84);
        checkOutput("t1_model_z", mZ, 84);
        @(posedge clk); #1;
        checkOutput("t1_out_valid_cleared", bus.out_valid, 0);

        $display("[TB] negative-weight vector");
        loadWeights(1);
        foreach (tbX[i]) tbX[i] = 255;
        applyStimulus(BEATS, 0, -1, 0, 0, cyc);
        checkOutput("t2_model_raw", mRaw, -21420);
        checkOutput("t2_z_relu", bus.z, 0);
        @(posedge clk); #1;

        $display("[TB] alternating weights with gaps and backpressure");
        loadWeights(2);
        foreach (tbX[i]) tbX[i] = i;
        bus.out_ready = 1'b0;
        hsBefore = dutHs;
        applyStimulus(BEATS, 2, -1, 0, 0, cyc);
        bus.in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            checkOutput("t3_hold_valid", bus.out_valid, 1);
            checkOutput("t3_hold_in_ready", bus.in_ready, 0);
            checkOutput("t3_hold_z", bus.z, 1638);
        end
        checkOutput("t3_model_raw", mRaw, 1638);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t3_handshakes", dutHs - hsBefore, 1);

        $display("[TB] weight write timing");
        loadWeights(0);
        foreach (tbX[i]) tbX[i] = 0;
        tbX[0] = 1;
        applyStimulus(BEATS, 0, 0, 0, 7, cyc);
        checkOutput("t4_write_with_first_beat", bus.z, 1);
        @(posedge clk); #1;
        applyStimulus(BEATS, 0, 5, 0, 5, cyc);
        checkOutput("t4_new_weight_used", bus.z, 7);
        @(posedge clk); #1;
        writeWeight(100, 50);
        foreach (tbX[i]) tbX[i] = 1;
        applyStimulus(BEATS, 0, -1, 0, 0, cyc);
        checkOutput("t4_acc_write_ignored", bus.z, 90);
        @(posedge clk); #1;

        $display("[TB] reset mid-vector");
        applyStimulus(10, 0, -1, 0, 0, cyc);
        checkOutput("t5_busy_before_reset", bus.busy, 1);
        rst_n = 1'b0; #2;
        checkOutput("t5_rst_out_valid", bus.out_valid, 0);
        checkOutput("t5_rst_busy", bus.busy, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(BEATS, 0, -1, 0, 0, cyc);
        checkOutput("t5_zero_weights_z", bus.z, 0);
        checkOutput("t5_model_raw", mRaw, 0);
        @(posedge clk); #1;

        $display("[TB] IN=6 instance with padded lanes");
        for (int i = 0; i < IN2; i++) begin
            bus2.w_we = 1'b1; bus2.w_addr = ADDR2_W'(i); bus2.w_data = W_WIDTH'(i + 1);
            @(posedge clk); #1;
        end
        bus2.w_we = 1'b0;
        bus2.in_valid = 1'b1;
        bus2.in_data = {8'd2, 8'd2, 8'd2, 8'd2};
        @(negedge clk);
        checkOutput("d2_in_ready", bus2.in_ready, 1);
        @(posedge clk); #1;
        checkOutput("d2_not_done_after_beat0", bus2.out_valid, 0);
        bus2.in_data = {8'hFF, 8'hFF, 8'd2, 8'd2};
        @(posedge clk); #1;
        bus2.in_valid = 1'b0;
        checkOutput("d2_valid", bus2.out_valid, 1);
        checkOutput("d2_z", bus2.z, 42);
        @(posedge clk); #1;
        checkOutput("d2_cleared", bus2.out_valid, 0);

`ifdef FC_NEURON_SEQ_BIAS_EN
        $display("[TB] bias cases");
        loadWeights(0);
        writeWeight(IN, -10);
        foreach (tbX[i]) tbX[i] = 1;
        applyStimulus(BEATS, 0, -1, 0, 0, cyc);
        checkOutput("bias_m10_z", bus.z, 74);
        checkOutput("bias_m10_model", mZ, 74);
        @(posedge clk); #1;
        writeWeight(IN, -100);
        applyStimulus(BEATS, 0, -1, 0, 0, cyc);
        checkOutput("bias_m100_z", bus.z, 0);
        checkOutput("bias_m100_raw", mRaw, -16);
        @(posedge clk); #1;
`endif

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end
endmodule

// File: doc/fc_neuron_seq.md
Name: fc_neuron_seq

Overview:
- Time-multiplexed, parametrised fully-connected neuron: one output = ReLU(sum of x[i]*w[i] (+ bias)).
- Weights are runtime-loadable; the block does not use a fixed constant-multiplier tree.
- Activations stream in LANES elements per beat. LANES signed multipliers feed one accumulator.
- Sits between a conv/pool output stream and the next FC stage. One instance per output neuron.

Parameters:
- WIDTH, 8, activation width (unsigned input x).
- W_WIDTH, 8, weight width (signed two's complement).
- IN, 84, number of inputs (fan-in).
- LANES, 4, multipliers / activations per beat; 1 <= LANES <= IN.
- Derived: BEATS = ceil(IN/LANES); ACC_W = WIDTH+W_WIDTH+$clog2(IN)+1 (signed accumulator).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- w_we  in  1  weight write strobe.
- w_addr  in  $clog2(IN)  weight index.
- w_data  in  W_WIDTH  signed weight value.
- in_valid  in  1  activation beat valid.
- in_ready  out  1  block accepts a beat.
- in_data  in  WIDTH*LANES  lane k = bits [k*WIDTH +: WIDTH] = x[beat*LANES+k].
- out_valid  out  1  z valid.
- out_ready  in  1  downstream accepts z.
- z  out  ACC_W-1  ReLU result, unsigned, non-negative.
- busy  out  1  high in ACC or DONE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=0 while in reset, 1 after the first clock edge with rst_n=1.
  - out_valid=0, z=0, busy=0, accumulator=0, beat counter=0.
  - All IN weights = 0.
- FSM:
  - IDLE: in_ready=1. Accepted beat (in_valid&in_ready) -> acc = partial(beat0), cnt=1, go ACC. If BEATS==1, go DONE instead.
  - ACC: in_ready=1. Each accepted beat -> acc += partial(beat cnt), cnt++. Beat BEATS-1 accepted -> go DONE. Idle cycles (in_valid=0) hold state.
  - DONE: in_ready=0, out_valid=1, z held stable. out_valid&out_ready -> go IDLE, out_valid=0 next cycle, acc and cnt cleared.
- partial(b) = signed sum over k of $signed({1'b0,x_k}) * w[b*LANES+k].
  - Lanes with index b*LANES+k >= IN contribute 0; their in_data bits are ignored.
- Latency: out_valid asserts the cycle after the last beat is accepted.
  - Minimum throughput: BEATS+1 cycles per result with out_ready tied high. No overlap of successive vectors.
- Output:
  - z = (final_sum < 0) ? 0 : final_sum[ACC_W-2:0], registered on entry to DONE.
  - No saturation is needed: ACC_W is sized so the sum never overflows.
- Weight writes:
  - Honoured only in IDLE: w[w_addr] <= w_data on the clock edge.
  - In ACC/DONE, w_we is silently ignored.
  - w_addr >= IN is ignored.
  - A write and an accepted first beat in the same IDLE cycle: the beat uses the old weights; the write takes effect afterwards.
- busy = (state != IDLE).
- Reset mid-operation aborts the vector immediately. No output is produced for the partial vector, and weights return to 0.
- in_valid during DONE is not accepted (in_ready=0). Upstream must hold data per valid/ready rules.

Optional Feature:
- Macro FC_NEURON_SEQ_BIAS_EN.
- Defined:
  - Adds a signed W_WIDTH+WIDTH bias register, reset value 0.
  - Written via w_we with w_addr == IN; w_addr width becomes $clog2(IN+1).
  - Bias is sign-extended and loaded as the accumulator start value on beat0, so final_sum = bias + sum(products) before ReLU.
  - ACC_W gains 1 bit.
- Undefined: no bias; writes at w_addr == IN are ignored; widths as listed above.

Test Plan:
- IN=84, LANES=4, all weights 1, all x=1, out_ready=1 -> 21 beats accepted; out_valid on cycle 22 after first beat; z=84.
- Same setup, all weights -1 (8'hFF), x=255 -> raw sum -21420; z=0.
- Alternating weights +3/-2, x[i]=i, random in_valid gaps, out_ready low for 5 cycles in DONE -> z held stable; in_ready=0 throughout DONE; correct sum computed against a software model; exactly one handshake.
- IN=6, LANES=4, weights 1..6, x all 2 -> 2 beats; lanes 2,3 of beat 1 set to 8'hFF must be ignored; z=42.
- Write w[0]=5 during ACC -> ignored (weight stays old value); rst_n pulsed low after 10 beats -> out_valid=0, busy=0, next vector computed with all-zero weights gives z=0.
- With FC_NEURON_SEQ_BIAS_EN: weights all 1, x all 1, bias=-10 (IN=84) -> z=74; bias=-100 -> z=0.
